// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity helper and the default baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DEFAULT_DIV = 868;

    // Even parity when odd == 0; data narrower than 8 bits is zero-extended by the caller.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count and a
// one-cycle overflow pulse for writes dropped while full.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_wr, do_rd;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    always_comb begin
        do_wr      = wr_en && !full;
        do_rd      = rd_en && !empty;
        wr_ptr_d   = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - (AW+1)'(1);
        end
        overflow_d = wr_en && full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal FIFO; frame settings are latched
// when a word is popped so mid-frame changes only affect later frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        tx_en,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic                        parity_en,
    input  logic                        odd_parity,
    input  logic                        two_stop,
    output logic                        tx_out,
    output logic                        busy
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_t         state_q, state_d;
    logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_bit_q, par_bit_d;
    logic              par_en_q, par_en_d;
    logic              two_stop_q, two_stop_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              pop, bit_end, start_ok;
    logic [DATA_W-1:0] head;
    logic [7:0]        head_ext;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count),
        .overflow (overflow)
    );

    assign tx_out = tx_q;
    assign busy   = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        stop2_d    = stop2_q;
        pop        = 1'b0;
        head_ext   = '0;
        head_ext[DATA_W-1:0] = head;
        bit_end    = (baud_cnt_q == div_q - DIV_W'(1));
        start_ok   = tx_en && !empty;
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIV_W'(1);

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                pop        = start_ok;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BW'(DATA_W - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        stop2_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop2_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else if (start_ok) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Popping from IDLE or at the end of STOP starts the next frame with no gap.
        if (pop) begin
            state_d    = START;
            shift_d    = head;
            div_d      = (baud_div == '0) ? DIV_W'(1) : baud_div;
            par_bit_d  = calc_parity(head_ext, odd_parity);
            par_en_d   = parity_en;
            two_stop_d = two_stop;
            stop2_d    = 1'b0;
            baud_cnt_d = '0;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            div_q      <= DIV_W'(1);
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated synchronous transmit FIFO.
- Runtime baud divisor, data width, parity mode (none/even/odd) and 1 or 2 stop bits.
- Sits between the processor-side write port and the serial pin.
- Sends back-to-back frames with no idle gap while the FIFO holds data and tx_en is high.

Parameters:
DATA_W, 8, frame data bits (5..8)
FIFO_DEPTH, 16, FIFO entries (power of two, >=2)
DIV_W, 16, baud divisor width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous and active-high
wr_en  in  1  push wr_data into FIFO
wr_data  in  DATA_W  word to transmit
full  out  1  FIFO full
empty  out  1  FIFO empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
overflow  out  1  one-cycle pulse: write dropped because FIFO full
tx_en  in  1  permit starting new frames
baud_div  in  DIV_W  clocks per bit; 0 treated as 1
parity_en  in  1  append parity bit
odd_parity  in  1  1=odd, 0=even parity
two_stop  in  1  1=two stop bits
tx_out  out  1  serial line, idle high
busy  out  1  frame in progress

Behaviour:
- Reset (sync, active-high):
  - tx_out=1, busy=0, overflow=0, empty=1, full=0, fifo_count=0.
  - FIFO pointers cleared. State IDLE.
  - Reset mid-frame aborts the frame: tx_out=1 from the next edge.
- FIFO:
  - Circular buffer; write accepted when wr_en && !full.
  - wr_en && full: data dropped, overflow=1 next cycle.
  - A written word is poppable from the next cycle.
  - Write and pop in the same cycle: count unchanged, both pointers advance. If full, the write is still dropped.
- Config latch:
  - baud_div, parity_en, odd_parity, two_stop are sampled at pop (frame start).
  - Changes mid-frame affect only later frames.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if tx_en && !empty, pop head into shift register, latch config, go to START next cycle. Otherwise stay; tx_out=1.
  - START: tx_out=0 for baud_div cycles, then DATA.
  - DATA: DATA_W bits, LSB first, each baud_div cycles. After the last bit, go to PARITY if parity_en, else STOP.
  - PARITY: tx_out = ^data XOR odd_parity, for baud_div cycles, then STOP.
  - STOP: tx_out=1 for baud_div cycles (1 stop bit) or 2*baud_div cycles (two_stop).
  - At STOP end: if tx_en && !empty, pop and go directly to START on the next edge (no idle gap). Otherwise go to IDLE.
- Baud counter:
  - Counts 0..div-1, resets at each bit boundary.
  - Bit counter counts 0..DATA_W-1.
- busy = (state != IDLE).
- tx_out is registered: first start-bit cycle is the cycle after the pop.
- tx_en deasserted mid-frame: current frame completes; no new frame starts.
- Frame length in clocks: div*(1+DATA_W+parity_en+1+two_stop).

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - parity helper function
  - default divisor constant (868)
- Sub-module uart_sync_fifo holds the FIFO: parameters WIDTH and DEPTH; outputs full, empty, count, overflow.
- The FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
- DATA_W=8, baud_div=4, parity off, 1 stop; write 0xA5, tx_en=1 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; busy high for 40 clocks.
- Same 0xA5 with parity_en=1 -> parity bit 0 when odd_parity=0, 1 when odd_parity=1. With two_stop=1, frame = 48 clocks.
- Write 0x01, 0x02, 0x03 with tx_en=1 -> three frames contiguous: stop-bit end followed by start bit on the next edge; empty=1 after the third pop.
- FIFO_DEPTH=4, tx_en=0; write 5 words -> full=1 after the 4th, 5th dropped, overflow pulses one cycle, fifo_count=4.
- Change baud_div 4->8 mid-frame -> current frame keeps 4 clocks/bit; next frame uses 8.
- Assert rst during DATA bit 3 -> next edge: tx_out=1, busy=0, empty=1, fifo_count=0; a new write then transmits normally.
